// File: rtl/bus_transfer_ctrl.sv
// Register-transfer sequencer for a shared tri-state bus: drives one-hot Tx/ldx strobes per move.
// Optional one-entry pending request slot when BUS_XFER_QUEUE_EN is defined.
module bus_transfer_ctrl #(
  parameter int unsigned NREG = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [IDXW-1:0] req_src,
  input  logic [IDXW-1:0] req_dst,
  input  logic            req_ext,
  output logic [NREG-1:0] tx_en,
  output logic            ext_tx,
  output logic [NREG-1:0] ld_en,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [1:0] {StIdle, StDrive, StLoad, StDone} state_e;

  localparam logic [NREG-1:0] OneHot = {{(NREG-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [IDXW-1:0] src_q, src_d, dst_q, dst_d;
  logic            ext_q, ext_d;

  logic            start;
  logic [IDXW-1:0] cand_src, cand_dst;
  logic            cand_ext;
  logic            bad, noop;

  logic [NREG-1:0] tx_en_d, ld_en_d;
  logic            ext_tx_d, busy_d, done_d, err_d, drive_d;

  function automatic logic idx_bad(logic [IDXW-1:0] idx);
    return {1'b0, idx} >= (IDXW+1)'(NREG);
  endfunction

`ifdef BUS_XFER_QUEUE_EN
  logic            accept, can_start;
  logic            slot_vld_q, slot_vld_d;
  logic [IDXW-1:0] slot_src_q, slot_dst_q;
  logic            slot_ext_q;

  assign req_ready = rst_n & ~slot_vld_q;

  // A pending slot entry always wins over a fresh request; ready is low then anyway.
  always_comb begin
    accept     = req_valid & req_ready;
    can_start  = (state_q == StIdle) | (state_q == StDone);
    start      = can_start & (slot_vld_q | accept);
    cand_src   = slot_vld_q ? slot_src_q : req_src;
    cand_dst   = slot_vld_q ? slot_dst_q : req_dst;
    cand_ext   = slot_vld_q ? slot_ext_q : req_ext;
    slot_vld_d = slot_vld_q;
    if (can_start & slot_vld_q) begin
      slot_vld_d = 1'b0;
    end else if (~can_start & accept) begin
      slot_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_vld_q <= 1'b0;
      slot_src_q <= '0;
      slot_dst_q <= '0;
      slot_ext_q <= 1'b0;
    end else begin
      slot_vld_q <= slot_vld_d;
      if (~can_start & accept) begin
        slot_src_q <= req_src;
        slot_dst_q <= req_dst;
        slot_ext_q <= req_ext;
      end
    end
  end
`else
  assign req_ready = rst_n & ((state_q == StIdle) | (state_q == StDone));

  always_comb begin
    start    = req_valid & req_ready;
    cand_src = req_src;
    cand_dst = req_dst;
    cand_ext = req_ext;
  end
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    ext_d   = ext_q;
    err_d   = 1'b0;
    bad     = idx_bad(cand_dst) | (~cand_ext & idx_bad(cand_src));
    noop    = ~cand_ext & (cand_src == cand_dst);
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          if (bad | noop) begin
            // Consumed without touching the bus.
            state_d = StDone;
            err_d   = bad;
          end else begin
            state_d = StDrive;
            src_d   = cand_src;
            dst_d   = cand_dst;
            ext_d   = cand_ext;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StDrive: state_d = StLoad;
      StLoad:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from next state so they come straight out of flops.
  always_comb begin
    drive_d  = (state_d == StDrive) | (state_d == StLoad);
    tx_en_d  = (drive_d & ~ext_d) ? (OneHot << src_d) : '0;
    ext_tx_d = drive_d & ext_d;
    ld_en_d  = (state_d == StLoad) ? (OneHot << dst_d) : '0;
    done_d   = state_d == StDone;
    busy_d   = state_d != StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      ext_q   <= 1'b0;
      tx_en   <= '0;
      ext_tx  <= 1'b0;
      ld_en   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      ext_q   <= ext_d;
      tx_en   <= tx_en_d;
      ext_tx  <= ext_tx_d;
      ld_en   <= ld_en_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Directed bench for bus_transfer_ctrl: NREG=4 main instance plus NREG=3 instance for range errors.
// A small bus-register model driven by the strobes checks the data actually moved.
module tb_bus_transfer_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       req_valid, req_ready, req_ext;
  logic [1:0] req_src, req_dst;
  logic [3:0] tx_en, ld_en;
  logic       ext_tx, busy, done, err;

  logic       v3, r3, e3;
  logic [1:0] s3, d3;
  logic [2:0] tx3, ld3;
  logic       x3, b3, dn3, er3;

  int vecs = 0;
  int errs = 0;

  localparam logic [3:0] ExtData = 4'h5;
  logic [3:0] breg [4] = '{4'h3, 4'h6, 4'h9, 4'hC};
  logic [3:0] bus;

  always_comb begin
    bus = '0;
    if (ext_tx) bus = ExtData;
    for (int i = 0; i < 4; i++) if (tx_en[i]) bus = bus | breg[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (ld_en[i]) breg[i] <= bus;
  end

  bus_transfer_ctrl #(.NREG(4), .IDXW(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .req_ext(req_ext), .tx_en(tx_en),
    .ext_tx(ext_tx), .ld_en(ld_en), .busy(busy), .done(done), .err(err)
  );

  bus_transfer_ctrl #(.NREG(3), .IDXW(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(r3),
    .req_src(s3), .req_dst(d3), .req_ext(e3), .tx_en(tx3),
    .ext_tx(x3), .ld_en(ld3), .busy(b3), .done(dn3), .err(er3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = 0; req_src = 0; req_dst = 0; req_ext = 0;
    v3 = 0; s3 = 0; d3 = 0; e3 = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if ({tx_en, ext_tx, ld_en, busy, done, err} !== 12'h0) begin
      errs++; $display("FAIL reset_outputs: got %h expected 000", {tx_en, ext_tx, ld_en, busy, done, err});
    end
    vecs++;
    if ({tx3, x3, ld3, b3, dn3, er3} !== 10'h0) begin
      errs++; $display("FAIL reset_outputs3: got %h expected 000", {tx3, x3, ld3, b3, dn3, er3});
    end
    rst_n = 1;
    #1;
    vecs++;
    if (req_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    vecs++;
    if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tick();
  endtask

  task automatic test_basic_move();
    req_valid = 1; req_src = 1; req_dst = 3; req_ext = 0;
    tick();
    req_valid = 0;
    vecs++;
    if ({tx_en, ld_en, ext_tx, done} !== {4'b0010, 4'b0000, 1'b0, 1'b0}) begin
      errs++; $display("FAIL move_drive: got tx=%b ld=%b ext=%b done=%b expected tx=0010 ld=0000", tx_en, ld_en, ext_tx, done);
    end
    vecs++;
    if (busy !== 1'b1) begin errs++; $display("FAIL move_busy: got %b expected 1", busy); end
    tick();
    vecs++;
    if ({tx_en, ld_en, done} !== {4'b0010, 4'b1000, 1'b0}) begin
      errs++; $display("FAIL move_load: got tx=%b ld=%b done=%b expected tx=0010 ld=1000 done=0", tx_en, ld_en, done);
    end
    tick();
    vecs++;
    if ({tx_en, ld_en, done} !== {4'b0000, 4'b0000, 1'b1}) begin
      errs++; $display("FAIL move_done: got tx=%b ld=%b done=%b expected 0000 0000 1", tx_en, ld_en, done);
    end
    tick();
    vecs++;
    if ({done, busy, req_ready} !== 3'b001) begin
      errs++; $display("FAIL move_idle: got done,busy,ready=%b expected 001", {done, busy, req_ready});
    end
    vecs++;
    if (breg[3] !== 4'h6) begin errs++; $display("FAIL move_data: got %h expected 6", breg[3]); end
  endtask

  task automatic test_ext_load();
    req_valid = 1; req_src = 2; req_dst = 0; req_ext = 1;
    tick();
    req_valid = 0; req_ext = 0;
    vecs++;
    if ({ext_tx, tx_en, ld_en} !== {1'b1, 4'b0000, 4'b0000}) begin
      errs++; $display("FAIL ext_drive: got ext=%b tx=%b ld=%b expected 1 0000 0000", ext_tx, tx_en, ld_en);
    end
    tick();
    vecs++;
    if ({ext_tx, tx_en, ld_en} !== {1'b1, 4'b0000, 4'b0001}) begin
      errs++; $display("FAIL ext_load: got ext=%b tx=%b ld=%b expected 1 0000 0001", ext_tx, tx_en, ld_en);
    end
    tick();
    vecs++;
    if ({ext_tx, ld_en, done} !== {1'b0, 4'b0000, 1'b1}) begin
      errs++; $display("FAIL ext_done: got ext=%b ld=%b done=%b expected 0 0000 1", ext_tx, ld_en, done);
    end
    tick();
    vecs++;
    if (breg[0] !== ExtData) begin errs++; $display("FAIL ext_data: got %h expected %h", breg[0], ExtData); end
  endtask

  task automatic test_noop();
    req_valid = 1; req_src = 2; req_dst = 2; req_ext = 0;
    tick();
    req_valid = 0;
    vecs++;
    if ({done, err, tx_en, ld_en, ext_tx} !== {1'b1, 1'b0, 4'b0, 4'b0, 1'b0}) begin
      errs++; $display("FAIL noop_done: got done=%b err=%b tx=%b ld=%b ext=%b expected 1 0 0000 0000 0",
                       done, err, tx_en, ld_en, ext_tx);
    end
    tick();
    vecs++;
    if ({done, busy} !== 2'b00) begin errs++; $display("FAIL noop_idle: got %b expected 00", {done, busy}); end
  endtask

  task automatic test_error();
    v3 = 1; s3 = 0; d3 = 3; e3 = 0;
    tick();
    v3 = 0;
    vecs++;
    if ({er3, dn3, tx3, ld3, x3} !== {1'b1, 1'b1, 3'b0, 3'b0, 1'b0}) begin
      errs++; $display("FAIL err_dst: got err=%b done=%b tx=%b ld=%b expected 1 1 000 000", er3, dn3, tx3, ld3);
    end
    tick();
    vecs++;
    if ({er3, dn3} !== 2'b00) begin errs++; $display("FAIL err_clear: got %b expected 00", {er3, dn3}); end
    v3 = 1; s3 = 3; d3 = 1; e3 = 0;
    tick();
    v3 = 0;
    vecs++;
    if ({er3, dn3, tx3} !== {1'b1, 1'b1, 3'b0}) begin
      errs++; $display("FAIL err_src: got err=%b done=%b tx=%b expected 1 1 000", er3, dn3, tx3);
    end
    tick();
    // External source ignores an out-of-range src field.
    v3 = 1; s3 = 3; d3 = 2; e3 = 1;
    tick();
    v3 = 0; e3 = 0;
    vecs++;
    if ({er3, x3, tx3} !== {1'b0, 1'b1, 3'b0}) begin
      errs++; $display("FAIL ext_src_ignored: got err=%b ext=%b tx=%b expected 0 1 000", er3, x3, tx3);
    end
    tick();
    vecs++;
    if (ld3 !== 3'b100) begin errs++; $display("FAIL ext3_load: got %b expected 100", ld3); end
    tick();
    vecs++;
    if ({dn3, er3} !== 2'b10) begin errs++; $display("FAIL ext3_done: got %b expected 10", {dn3, er3}); end
    tick();
  endtask

  task automatic test_reset_in_load();
    req_valid = 1; req_src = 2; req_dst = 1; req_ext = 0;
    tick();
    req_valid = 0;
    tick();
    vecs++;
    if (ld_en !== 4'b0010) begin errs++; $display("FAIL rst_pre_load: got %b expected 0010", ld_en); end
    #2;
    rst_n = 0;
    #1;
    vecs++;
    if ({tx_en, ld_en, ext_tx, busy} !== 10'h0) begin
      errs++; $display("FAIL rst_mid_drop: got tx=%b ld=%b ext=%b busy=%b expected all 0", tx_en, ld_en, ext_tx, busy);
    end
    tick();
    rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      vecs++;
      if (done !== 1'b0) begin errs++; $display("FAIL rst_no_done: cycle %0d got %b expected 0", k, done); end
    end
    vecs++;
    if (breg[1] !== 4'h6) begin errs++; $display("FAIL rst_no_load: got %h expected 6", breg[1]); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_tx   [7] = '{4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic [3:0] exp_ld   [7] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    logic       exp_done [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_busy [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`ifdef BUS_XFER_QUEUE_EN
    logic       exp_rdy  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int         drop_k = 2;
`else
    logic       exp_rdy  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int         drop_k = 4;
`endif
    req_valid = 1; req_src = 0; req_dst = 1; req_ext = 0;
    tick();
    req_src = 2; req_dst = 3;
    for (int k = 0; k < 7; k++) begin
      vecs++;
      if ({tx_en, ld_en, done, busy} !== {exp_tx[k], exp_ld[k], exp_done[k], exp_busy[k]}) begin
        errs++;
        $display("FAIL b2b_cycle%0d: got tx=%b ld=%b done=%b busy=%b expected tx=%b ld=%b done=%b busy=%b",
                 k + 1, tx_en, ld_en, done, busy, exp_tx[k], exp_ld[k], exp_done[k], exp_busy[k]);
      end
      vecs++;
      if (req_ready !== exp_rdy[k]) begin
        errs++; $display("FAIL b2b_ready%0d: got %b expected %b", k + 1, req_ready, exp_rdy[k]);
      end
      vecs++;
      if (($countones(tx_en) + int'(ext_tx)) > 1 || $countones(ld_en) > 1 ||
          (ld_en != 4'b0 && tx_en == 4'b0 && !ext_tx)) begin
        errs++; $display("FAIL b2b_invariant%0d: got tx=%b ext=%b ld=%b expected single driver", k + 1, tx_en, ext_tx, ld_en);
      end
      if (k + 1 == drop_k) req_valid = 0;
      if (k < 6) tick();
    end
    vecs++;
    if ({breg[1], breg[3]} !== {ExtData, 4'h9}) begin
      errs++; $display("FAIL b2b_data: got r1=%h r3=%h expected r1=%h r3=9", breg[1], breg[3], ExtData);
    end
  endtask

  initial begin
    test_reset();
    test_basic_move();
    test_ext_load();
    test_noop();
    test_error();
    test_reset_in_load();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
